// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device byte transmitter with open-drain line
//               control, request-to-send sequencing and device ACK check.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 20,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       ps2clk_drive_low,
    output logic       ps2data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_CNT_MAX =
        (TIMEOUT_CYCLES > INHIBIT_CYCLES)
            ? ((TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES)
            : ((INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES);
    localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RTS_LAST = c_CNT_W'(RTS_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam int c_FLT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [c_FLT_W-1:0] c_FLT_LAST = c_FLT_W'(FILTER_LEN - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_INHIBIT = 3'd1;
    localparam logic [2:0] c_ST_RTS     = 3'd2;
    localparam logic [2:0] c_ST_SHIFT   = 3'd3;
    localparam logic [2:0] c_ST_ACK     = 3'd4;
    localparam logic [2:0] c_ST_RELEASE = 3'd5;

    // Index 0 = PS2Clk, index 1 = PS2Data
    logic [1:0] w_line_in;
    logic [1:0] w_filt;
    assign w_line_in = {PS2Data, PS2Clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic [1:0]         r_sync;
            logic               r_lvl;
            logic [c_FLT_W-1:0] r_fcnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= 2'b11;
                    r_lvl  <= 1'b1;
                    r_fcnt <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_line_in[gi]};
                    // Level only follows after FILTER_LEN consecutive differing samples
                    if (r_sync[1] == r_lvl) begin
                        r_fcnt <= '0;
                    end else if (r_fcnt == c_FLT_LAST) begin
                        r_lvl  <= r_sync[1];
                        r_fcnt <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    logic w_clk_f;
    logic w_data_f;
    logic r_clk_prev;
    logic w_fall;

    assign w_clk_f  = w_filt[0];
    assign w_data_f = w_filt[1];
    assign w_fall   = r_clk_prev & ~w_clk_f;

    logic [2:0]         r_state,    w_state;
    // In SHIFT/ACK/RELEASE: clk cycles elapsed since the last fall or SHIFT entry
    logic [c_CNT_W-1:0] r_cnt,      w_cnt;
    logic [3:0]         r_bit_idx,  w_bit_idx;
    logic [8:0]         r_shift,    w_shift;
    logic               r_clk_low,  w_clk_low;
    logic               r_data_low, w_data_low;
    logic               r_busy,     w_busy;
    logic               r_done,     w_done;
    logic               r_error,    w_error;
    logic               w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit_idx  <= w_bit_idx;
            r_shift    <= w_shift;
            r_clk_low  <= w_clk_low;
            r_data_low <= w_data_low;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit_idx  = r_bit_idx;
        w_shift    = r_shift;
        w_clk_low  = r_clk_low;
        w_data_low = r_data_low;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_error    = 1'b0;
        w_timeout  = (r_cnt == c_TMO_LAST);

        case (r_state)
            c_ST_IDLE: begin
                w_clk_low  = 1'b0;
                w_data_low = 1'b0;
                w_busy     = 1'b0;
                if (tx_start) begin
                    w_shift   = {~^tx_data, tx_data};
                    w_bit_idx = '0;
                    w_cnt     = '0;
                    w_busy    = 1'b1;
                    w_clk_low = 1'b1;
                    w_state   = c_ST_INHIBIT;
                end
            end
            c_ST_INHIBIT: begin
                if (r_cnt == c_INH_LAST) begin
                    w_cnt      = '0;
                    w_data_low = 1'b1;
                    w_state    = c_ST_RTS;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_RTS: begin
                // Start bit stays on the data line as the clock is handed to the device
                if (r_cnt == c_RTS_LAST) begin
                    w_cnt     = '0;
                    w_clk_low = 1'b0;
                    w_state   = c_ST_SHIFT;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_SHIFT: begin
                if (w_fall) begin
                    w_cnt = c_CNT_ONE;
                    if (r_bit_idx == 4'd9) begin
                        w_data_low = 1'b0;
                        w_state    = c_ST_ACK;
                    end else begin
                        w_data_low = ~r_shift[0];
                        w_shift    = {1'b0, r_shift[8:1]};
                        w_bit_idx  = r_bit_idx + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_clk_low  = 1'b0;
                    w_data_low = 1'b0;
                    w_busy     = 1'b0;
                    w_error    = 1'b1;
                    w_state    = c_ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_ACK: begin
                if (w_fall) begin
                    w_cnt = c_CNT_ONE;
                    if (!w_data_f) begin
                        w_state = c_ST_RELEASE;
                    end else begin
                        w_busy  = 1'b0;
                        w_error = 1'b1;
                        w_state = c_ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_clk_low  = 1'b0;
                    w_data_low = 1'b0;
                    w_busy     = 1'b0;
                    w_error    = 1'b1;
                    w_state    = c_ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_RELEASE: begin
                if (w_clk_f && w_data_f) begin
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = c_ST_IDLE;
                end else if (w_fall) begin
                    w_cnt = c_CNT_ONE;
                end else if (w_timeout) begin
                    w_clk_low  = 1'b0;
                    w_data_low = 1'b0;
                    w_busy     = 1'b0;
                    w_error    = 1'b1;
                    w_state    = c_ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_clk_low  = 1'b0;
                w_data_low = 1'b0;
                w_busy     = 1'b0;
                w_state    = c_ST_IDLE;
            end
        endcase
    end

    assign ps2clk_drive_low  = r_clk_low;
    assign ps2data_drive_low = r_data_low;
    assign busy              = r_busy;
    assign tx_done           = r_done;
    assign tx_error          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Scoreboard bench for ps2_host_tx with a behavioural PS/2
//               device on wired-AND lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH      = 20;
    localparam int c_RTS      = 4;
    localparam int c_FLT      = 2;
    localparam int c_TMO      = 500;
    localparam int c_HALF     = 20;
    // Cycles from a line change to the fall strobe: 2 sync flops + filter
    localparam int c_FALL_LAT = 2 + c_FLT;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       PS2Clk;
    logic       PS2Data;
    logic       ps2clk_drive_low;
    logic       ps2data_drive_low;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch       = 1'b0;

    assign PS2Clk  = ~(ps2clk_drive_low | dev_clk_low | glitch);
    assign PS2Data = ~(ps2data_drive_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_INH),
        .RTS_CYCLES     (c_RTS),
        .FILTER_LEN     (c_FLT),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .PS2Clk            (PS2Clk),
        .PS2Data           (PS2Data),
        .ps2clk_drive_low  (ps2clk_drive_low),
        .ps2data_drive_low (ps2data_drive_low),
        .busy              (busy),
        .tx_done           (tx_done),
        .tx_error          (tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        bit         chk_bits;
        logic [9:0] bits;
        int         err_cyc;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [9:0] dev_seen;
    int         last_fall_cyc;
    bit         in_xfer = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as the device should see it: d0..d7, odd parity, stop
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic push_exp(input bit err, input bit chk_bits, input logic [7:0] d, input int err_cyc);
        exp_t e;
        e.err      = err;
        e.chk_bits = chk_bits;
        e.bits     = frame_of(d);
        e.err_cyc  = err_cyc;
        q.push_back(e);
    endtask

    task automatic start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        chk("busy_on_accept", busy, 1);
        in_xfer = 1'b1;
    endtask

    // Device side: waits for request-to-send, then clocks nfalls periods
    task automatic device_frame(input int nfalls, input bit ack);
        int w;
        dev_seen = '0;
        w = 0;
        while (!ps2clk_drive_low && w < 200) begin @(negedge clk); w++; end
        while (ps2clk_drive_low && w < 200) begin @(negedge clk); w++; end
        chk("rts_release_seen", (w < 200), 1);
        chk("start_bit", PS2Data, 0);
        repeat (10) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (c_HALF) @(negedge clk);
            if (k <= 10) dev_seen[k-1] = PS2Data;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            repeat (c_HALF) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 3000) begin @(negedge clk); w++; end
        chk("idle_reached", busy, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack);
        push_exp(!ack, 1'b1, d, -1);
        start(d);
        device_frame(11, ack);
        wait_idle();
    endtask

    // Monitor: phase lengths, busy continuity, and pulse scoreboard
    initial begin
        int   inh_len;
        int   rts_len;
        int   gap;
        exp_t e;
        inh_len = 0;
        rts_len = 0;
        gap     = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                inh_len = 0;
                rts_len = 0;
                gap     = 0;
            end else begin
                if (ps2clk_drive_low && !ps2data_drive_low) inh_len++;
                else if (inh_len != 0) begin
                    chk("inhibit_len", inh_len, c_INH);
                    inh_len = 0;
                end
                if (ps2clk_drive_low && ps2data_drive_low) rts_len++;
                else if (rts_len != 0) begin
                    chk("rts_len", rts_len, c_RTS);
                    rts_len = 0;
                end
                if (in_xfer && !busy && !tx_done && !tx_error) gap++;
                if (tx_done || tx_error) begin
                    chk("expect_pending", (q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("outcome_err", tx_error, e.err);
                        chk("pulse_excl", tx_done & tx_error, 0);
                        chk("busy_at_pulse", busy, 0);
                        chk("drives_at_pulse", {ps2clk_drive_low, ps2data_drive_low}, 0);
                        chk("busy_gap", gap, 0);
                        if (e.chk_bits) chk("frame_bits", dev_seen, e.bits);
                        if (e.err_cyc >= 0) chk("timeout_cycle", cyc, e.err_cyc);
                    end
                    gap     = 0;
                    in_xfer = 1'b0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {ps2clk_drive_low, ps2data_drive_low, busy, tx_done, tx_error}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed bytes
        xfer(8'hED, 1'b1);
        xfer(8'hF4, 1'b1);
        xfer(8'h00, 1'b1);

        // Missing ACK
        xfer(8'hFF, 1'b0);

        // Device stops clocking after the 4th fall
        start(8'hA5);
        device_frame(4, 1'b0);
        push_exp(1'b1, 1'b0, 8'hA5, last_fall_cyc + c_FALL_LAT + c_TMO);
        wait_idle();
        xfer(8'hF4, 1'b1);

        // Ignored second start and a one-cycle clock glitch
        push_exp(1'b0, 1'b1, 8'hFF, -1);
        start(8'hFF);
        fork
            device_frame(11, 1'b1);
            begin
                repeat (100) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (44) @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
            end
        join
        wait_idle();

        // Reset during SHIFT after 5 falls
        start(8'h3C);
        device_frame(5, 1'b0);
        reset   = 1'b1;
        in_xfer = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_abort", {ps2clk_drive_low, ps2data_drive_low, busy, tx_done, tx_error}, 0);
        repeat (5) @(negedge clk);
        xfer(8'hED, 1'b1);

        // Random bytes and ACK outcomes
        for (int i = 0; i < 6; i++) begin
            xfer(8'($urandom), ($urandom_range(3) != 0));
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
